// File: rtl/code_conv_arbiter.sv
// Purpose: shares one binary<->Gray converter between two requesters using round-robin arbitration.
// Latency: 1 cycle from accept to out_valid; sustains 1 result/cycle when out_ready is held high.
// Backpressure: out_valid & !out_ready freezes the result register and drops both input readies.
module code_conv_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in0_valid,
  input  logic         in0_mode,
  input  logic [W-1:0] in0_data,
  output logic         in0_ready,
  input  logic         in1_valid,
  input  logic         in1_mode,
  input  logic [W-1:0] in1_data,
  output logic         in1_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_id,
  output logic         out_mode,
  output logic [7:0]   conv_cnt
);

  // Gray->binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [W-1:0] f_g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         r_id;
  logic         r_mode;
  logic [7:0]   r_cnt;
  logic         r_rr_ptr;

  logic         w_can_load;
  logic         w_gnt;
  logic         w_acc;
  logic         w_sel_mode;
  logic [W-1:0] w_sel_data;
  logic [W-1:0] w_conv;

  // The register can take a new word when empty or when its current word leaves this cycle.
  assign w_can_load = ~r_valid | out_ready;

  // A lone requester wins outright; on a tie the round-robin pointer decides.
  assign w_gnt = (in0_valid & in1_valid) ? r_rr_ptr : in1_valid;

  assign in0_ready = w_can_load & ~w_gnt;
  assign in1_ready = w_can_load &  w_gnt;
  assign w_acc     = (in0_valid & in0_ready) | (in1_valid & in1_ready);

  assign w_sel_mode = w_gnt ? in1_mode : in0_mode;
  assign w_sel_data = w_gnt ? in1_data : in0_data;
  assign w_conv     = w_sel_mode ? f_g2b(w_sel_data) : (w_sel_data ^ (w_sel_data >> 1));

  // Result register, conversion counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_id     <= 1'b0;
      r_mode   <= 1'b0;
      r_cnt    <= 8'd0;
      r_rr_ptr <= 1'b0;
    end else if (w_acc) begin
      r_valid  <= 1'b1;
      r_data   <= w_conv;
      r_id     <= w_gnt;
      r_mode   <= w_sel_mode;
      r_cnt    <= r_cnt + 8'd1;
      r_rr_ptr <= ~w_gnt;
    end else if (out_ready) begin
      // Drain with nothing to reload: data fields keep their stale value.
      r_valid  <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_id    = r_id;
  assign out_mode  = r_mode;
  assign conv_cnt  = r_cnt;

endmodule

// File: tb/tb_code_conv_arbiter.sv
// Bench for code_conv_arbiter: directed steps with a reference model and a result queue.
// Expected words are pushed on accept and popped when the result register loads.
// Readies, valid, counter and held outputs are compared every cycle.
module tb_code_conv_arbiter;
  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in0_valid, in0_mode, in0_ready;
  logic [W-1:0] in0_data;
  logic         in1_valid, in1_mode, in1_ready;
  logic [W-1:0] in1_data;
  logic         out_valid, out_ready, out_id, out_mode;
  logic [W-1:0] out_data;
  logic [7:0]   conv_cnt;

  int total = 0;
  int bad   = 0;

  // model state
  logic         m_valid;
  logic         m_rr;
  logic [7:0]   m_cnt;
  logic [W+1:0] m_out;   // {id, mode, data}
  logic [W+1:0] sb_q[$];

  code_conv_arbiter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_mode(in0_mode), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_mode(in1_mode), .in1_data(in1_data), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .out_mode(out_mode), .conv_cnt(conv_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] m_b2g(input logic [W-1:0] b);
    logic [W-1:0] g;
    for (int i = 0; i < W - 1; i++) g[i] = b[i] ^ b[i+1];
    g[W-1] = b[W-1];
    return g;
  endfunction

  function automatic logic [W-1:0] m_g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int i = 0; i < W; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_rr    = 1'b0;
    m_cnt   = 8'd0;
    m_out   = '0;
    sb_q.delete();
  endtask

  // One clock cycle: entered just after a falling edge, leaves just after the next one.
  task automatic cycle(input logic v0, input logic md0, input logic [W-1:0] d0,
                       input logic v1, input logic md1, input logic [W-1:0] d1,
                       input logic ordy);
    logic can_load, gnt, r0, r1, acc, smode;
    logic [W-1:0] sdata, conv;
    in0_valid = v0; in0_mode = md0; in0_data = d0;
    in1_valid = v1; in1_mode = md1; in1_data = d1;
    out_ready = ordy;
    #1;
    can_load = !m_valid || ordy;
    if (v0 && v1) gnt = m_rr;
    else          gnt = v1;
    r0  = can_load && !gnt;
    r1  = can_load && gnt;
    acc = (v0 && r0) || (v1 && r1);
    chk("in0_ready", in0_ready, r0);
    chk("in1_ready", in1_ready, r1);
    if (acc) begin
      smode = gnt ? md1 : md0;
      sdata = gnt ? d1 : d0;
      conv  = smode ? m_g2b(sdata) : m_b2g(sdata);
      sb_q.push_back({gnt, smode, conv});
    end
    @(posedge clk);
    if (acc) begin
      m_valid = 1'b1;
      m_cnt   = m_cnt + 8'd1;
      m_rr    = ~gnt;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("conv_cnt", conv_cnt, m_cnt);
    if (acc) begin
      if (sb_q.size() == 0) chk("sb_empty", 1, 0);
      else m_out = sb_q.pop_front();
    end
    if (m_valid) begin
      chk("out_data", out_data, m_out[W-1:0]);
      chk("out_mode", out_mode, m_out[W]);
      chk("out_id",   out_id,   m_out[W+1]);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] g;
    logic [7:0]   c0;
    logic         exp_id;
    rst_n = 1'b0;
    in0_valid = 0; in0_mode = 0; in0_data = '0;
    in1_valid = 0; in1_mode = 0; in1_data = '0;
    out_ready = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data, 0);
    chk("rst_out_id",    out_id, 0);
    chk("rst_out_mode",  out_mode, 0);
    chk("rst_conv_cnt",  conv_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: binary->Gray from requester 0
    cycle(1, 0, 4'b1011, 0, 0, 4'b0000, 1);
    chk("t1_data", out_data, 4'b1110);
    chk("t1_id",   out_id, 0);
    chk("t1_cnt",  conv_cnt, 1);

    // 2: Gray->binary from requester 1, then round trip of every code
    cycle(0, 0, 4'b0000, 1, 1, 4'b1110, 1);
    chk("t2_data", out_data, 4'b1011);
    chk("t2_id",   out_id, 1);
    for (int c = 0; c < 16; c++) begin
      cycle(1, 0, c[W-1:0], 0, 0, 4'b0000, 1);
      g = out_data;
      cycle(0, 0, 4'b0000, 1, 1, g, 1);
      chk("rt_code", out_data, c[W-1:0]);
    end
    cycle(0, 0, 4'b0000, 0, 0, 4'b0000, 1);

    // 3: both valid every cycle -> alternating grants, no bubbles
    exp_id = m_rr;
    for (int k = 0; k < 8; k++) begin
      cycle(1, k[0], $urandom_range(0, 15), 1, ~k[0], $urandom_range(0, 15), 1);
      chk("alt_id", out_id, exp_id);
      chk("alt_valid", out_valid, 1);
      exp_id = ~exp_id;
    end

    // 4: three stalled cycles with both valid, then release
    for (int k = 0; k < 3; k++) begin
      cycle(1, 0, 4'b0101, 1, 1, 4'b0110, 0);
      chk("stall_rdy", {in0_ready, in1_ready}, 2'b00);
    end
    exp_id = m_rr;
    cycle(1, 0, 4'b0101, 1, 1, 4'b0110, 1);
    chk("release_id", out_id, exp_id);
    chk("release_valid", out_valid, 1);

    // 5: 256 accepts wrap the counter
    c0 = m_cnt;
    for (int k = 0; k < 256; k++) begin
      cycle(1, k[1], k[3:0], 0, 0, 4'b0000, 1);
    end
    chk("cnt_wrap", conv_cnt, c0);

    // 6: reset during a stall with a pending result
    cycle(1, 0, 4'b0011, 0, 0, 4'b0000, 0);
    cycle(1, 0, 4'b0011, 1, 0, 4'b0100, 0);
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt",   conv_cnt, 0);
    model_reset();
    in0_valid = 0; in1_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cycle(1, 0, 4'b1000, 1, 0, 4'b0001, 1);
    chk("post_rst_tie_id", out_id, 0);
    chk("post_rst_data", out_data, 4'b1100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Overall time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
